// File: rtl/if_stage.sv
// Instruction-fetch stage: reads instruction memory at the current PC into the IR, hands
// the IR to decode through a valid/ready handshake, and steps or redirects the PC.
module if_stage #(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               en_pc,
    output logic [1:0]         pc_ctrl,
    output logic [7:0]         offset_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               flush,
    input  logic [7:0]         flush_addr,
    output logic               fetch_fault
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_e;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]    ir_pc_q, ir_pc_d;
    logic                 ir_valid_q, ir_valid_d;
    logic                 fault_q, fault_d;
    logic                 flush_hit;

    // A fault parks the stage until reset, so a redirect is honoured only outside FAULT.
    assign flush_hit = flush && (state_q != FAULT);

    // NOTE: every register, including the IR payload, clears asynchronously so that a
    // reset between edges drops imem_req and ir_valid at once; state updates use <= only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
        end
    end

    // NOTE: each signal written here gets a hold-value default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;
        if (flush_hit) begin
            ir_valid_d = 1'b0;
            cnt_d      = 8'd0;
            state_d    = fetch_en ? REQ : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en) state_d = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = pc_in;
                        ir_valid_d = 1'b1;
                        cnt_d      = 8'd0;
                        state_d    = HOLD;
                    end else if (cnt_q >= WAIT_LAST) begin
                        cnt_d   = 8'd0;
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid_d = 1'b0;
                        state_d    = fetch_en ? REQ : IDLE;
                    end
                end
                FAULT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // The PC steps on the same edge that captures the word, keeping pc_in stable in REQ.
    always_comb begin
        en_pc       = 1'b0;
        pc_ctrl     = PC_HOLD;
        offset_addr = 8'd0;
        imem_req    = (state_q == REQ);
        if (flush_hit) begin
            en_pc       = 1'b1;
            pc_ctrl     = PC_LOAD;
            offset_addr = flush_addr;
        end else if ((state_q == REQ) && imem_ack) begin
            en_pc   = 1'b1;
            pc_ctrl = PC_INC;
        end
    end

    assign imem_addr   = pc_in;
    assign ir_out      = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small external PC model; expected values are hand-derived.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [15:0] pc;
    logic        en_pc;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] ir_out;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  flush_addr = 8'h00;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    if_stage #(.ADDR_W(16), .INSTR_W(16), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_in(pc),
        .en_pc(en_pc), .pc_ctrl(pc_ctrl), .offset_addr(offset_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir_out(ir_out), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .flush(flush),
        .flush_addr(flush_addr), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // External program counter: resets to 0x0001, increments or loads the zero-extended target.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 16'h0001;
        else if (en_pc) begin
            if (pc_ctrl == 2'b01) pc <= pc + 16'd1;
            else if (pc_ctrl == 2'b10) pc <= {8'h00, offset_addr};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        check("rst_ir_out", ir_out, 0);
        check("rst_ir_pc", ir_pc, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_fault", fetch_fault, 0);
        check("rst_req", imem_req, 0);
        check("rst_en_pc", en_pc, 0);
        check("rst_pc_ctrl", pc_ctrl, 0);
        check("rst_offset", offset_addr, 0);

        // First fetch: ack one cycle after the request.
        @(posedge clk); #1;
        rst = 1'b1; fetch_en = 1'b1; ir_ready = 1'b1;
        step();
        check("t1_req", imem_req, 1);
        check("t1_addr", imem_addr, 16'h0001);
        check("t1_no_en_wait", en_pc, 0);
        step();
        imem_ack = 1'b1; imem_rdata = 16'hA5C3; #1;
        check("t1_en_pc", en_pc, 1);
        check("t1_pc_inc", pc_ctrl, 2'b01);
        step();
        imem_ack = 1'b0; #1;
        check("t1_ir_out", ir_out, 16'hA5C3);
        check("t1_ir_pc", ir_pc, 16'h0001);
        check("t1_ir_valid", ir_valid, 1);
        check("t1_en_pc_once", en_pc, 0);
        check("t1_hold_req", imem_req, 0);
        step();
        check("t1_next_addr", imem_addr, 16'h0002);
        check("t1_consumed", ir_valid, 0);

        // Zero-wait fetch, then decode stalls for five cycles.
        imem_ack = 1'b1; imem_rdata = 16'h1234; ir_ready = 1'b0; #1;
        check("t2_en_pc", en_pc, 1);
        step();
        imem_ack = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", ir_valid, 1);
            check("t2_stall_ir", ir_out, 16'h1234);
            check("t2_stall_req", imem_req, 0);
            check("t2_stall_en", en_pc, 0);
            step();
        end
        ir_ready = 1'b1;
        step();
        check("t2_resume_req", imem_req, 1);
        check("t2_resume_addr", imem_addr, 16'h0003);
        check("t2_resume_valid", ir_valid, 0);

        // Flush coinciding with ack: data dropped, PC loaded.
        imem_ack = 1'b1; imem_rdata = 16'hDEAD; flush = 1'b1; flush_addr = 8'h40; #1;
        check("t3_en_pc", en_pc, 1);
        check("t3_pc_load", pc_ctrl, 2'b10);
        check("t3_offset", offset_addr, 8'h40);
        step();
        flush = 1'b0; imem_ack = 1'b0; #1;
        check("t3_valid", ir_valid, 0);
        check("t3_discard", ir_out, 16'h1234);
        check("t3_req", imem_req, 1);
        check("t3_addr", imem_addr, 16'h0040);

        // Timeout: fault on the 15th edge without ack.
        for (int i = 1; i <= 14; i++) begin
            step();
            check("t4_no_fault_yet", fetch_fault, 0);
        end
        step();
        check("t4_fault", fetch_fault, 1);
        check("t4_fault_req", imem_req, 0);
        flush = 1'b1; flush_addr = 8'h22; #1;
        check("t4_flush_ignored", en_pc, 0);
        step();
        check("t4_fault_sticky", fetch_fault, 1);
        check("t4_fault_still_idle", imem_req, 0);
        flush = 1'b0;
        rst = 1'b0; #1;
        check("t4_rst_clears", fetch_fault, 0);
        check("t4_rst_req", imem_req, 0);
        rst = 1'b1;

        // fetch_en dropped mid-REQ: finish the fetch, hand off, park in IDLE.
        step();
        check("t5_req", imem_req, 1);
        check("t5_addr", imem_addr, 16'h0001);
        fetch_en = 1'b0;
        step(); step(); step();
        check("t5_still_req", imem_req, 1);
        imem_ack = 1'b1; imem_rdata = 16'h5A5A; #1;
        check("t5_en_pc", en_pc, 1);
        step();
        imem_ack = 1'b0; #1;
        check("t5_ir_out", ir_out, 16'h5A5A);
        check("t5_ir_pc", ir_pc, 16'h0001);
        check("t5_ir_valid", ir_valid, 1);
        step();
        check("t5_handed", ir_valid, 0);
        check("t5_idle_req", imem_req, 0);
        step();
        check("t5_parked", imem_req, 0);

        // Asynchronous reset between edges during REQ.
        fetch_en = 1'b1;
        step();
        check("t6_req", imem_req, 1);
        check("t6_addr", imem_addr, 16'h0002);
        #1 rst = 1'b0;
        #1;
        check("t6_async_req", imem_req, 0);
        check("t6_async_valid", ir_valid, 0);
        check("t6_async_fault", fetch_fault, 0);
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage sitting between the program counter and the decode/control unit.
- Reads the PC value, issues a word read to instruction memory and captures the returned word in the instruction register (IR).
- Hands the IR to decode with a valid/ready handshake.
- Drives the PC control inputs: increment after each fetch, load on a branch flush. It is the only driver of the PC's en_pc, pc_ctrl and offset_addr.

Parameters:
ADDR_W, 16, width of PC and instruction-memory address
INSTR_W, 16, instruction word width
MAX_WAIT, 15, cycles in REQ without imem_ack before fetch_fault (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
fetch_en  input  1  run enable from top-level control
pc_in  input  ADDR_W  current PC value (PC pc_out)
en_pc  output  1  PC enable
pc_ctrl  output  2  PC command: 01 increment, 10 load
offset_addr  output  8  PC load target
imem_req  output  1  instruction memory read request (level)
imem_addr  output  ADDR_W  read address
imem_ack  input  1  read data valid this cycle
imem_rdata  input  INSTR_W  read data
ir_out  output  INSTR_W  instruction register
ir_pc  output  ADDR_W  address the IR word was fetched from
ir_valid  output  1  IR holds an unconsumed instruction
ir_ready  input  1  decode accepts the IR this cycle
flush  input  1  branch redirect from decode, one-cycle pulse
flush_addr  input  8  branch target
fetch_fault  output  1  sticky instruction-bus timeout flag

Behaviour:
- Interface: one clock, clk. rst is asynchronous active-low; all registers clear on rst==0 regardless of clk.
- Reset values: state=IDLE, ir_out=0, ir_pc=0, ir_valid=0, fetch_fault=0, wait counter=0.
- Combinational outputs at reset: imem_req=0, en_pc=0, pc_ctrl=00, offset_addr=0.
- States: IDLE, REQ, HOLD, FAULT.
- IDLE:
  - imem_req=0.
  - fetch_en=1 and flush=0 -> REQ.
- REQ:
  - imem_req=1; imem_addr=pc_in (combinational). pc_in is stable because the PC only changes on en_pc.
  - Wait counter increments each cycle without ack.
  - On imem_ack=1 and flush=0:
    - ir_out<=imem_rdata, ir_pc<=pc_in, ir_valid<=1, counter<=0, -> HOLD.
    - Same cycle: en_pc=1, pc_ctrl=01, so the PC increments on the same edge.
  - Counter reaches MAX_WAIT without ack -> FAULT.
- HOLD:
  - imem_req=0, ir_valid=1.
  - ir_ready=1 -> ir_valid<=0; then -> REQ if fetch_en=1, else IDLE.
  - Back-to-back throughput: one instruction every 2 cycles with zero-wait memory.
- FAULT:
  - imem_req=0, en_pc=0, fetch_fault=1.
  - flush and fetch_en are ignored. Exit only by reset.
- flush=1 in IDLE/REQ/HOLD (priority over imem_ack and ir_ready):
  - en_pc=1, pc_ctrl=10, offset_addr=flush_addr.
  - ir_valid<=0; any same-cycle imem_rdata is discarded; counter<=0.
  - Next state: REQ if fetch_en=1, else IDLE.
  - Instruction memory holds no outstanding transaction: dropping or retargeting imem_req mid-request is legal.
- fetch_en=0: does not abort an in-progress REQ or HOLD; the stage completes it, then parks in IDLE.
- Default outputs when none of the above apply: en_pc=0, pc_ctrl=00, offset_addr=0.
- Wait counter: 8-bit saturating, cleared on leaving REQ.
- Reset mid-REQ: imem_req drops immediately and any pending data is lost.
- The PC resets to 0x0001, so the first fetch after reset is from address 0x0001.

Test Plan:
- Reset release, fetch_en=1, memory acks 1 cycle after req with 0xA5C3, ir_ready=1 -> imem_addr=0x0001; ir_out=0xA5C3, ir_pc=0x0001, one-cycle en_pc/pc_ctrl=01; next req addr 0x0002.
- Decode holds ir_ready=0 for 5 cycles -> ir_valid and ir_out stable, imem_req=0, no en_pc pulses; release -> fetch of 0x0003.
- flush=1, flush_addr=0x40 coinciding with imem_ack -> data discarded, ir_valid=0, en_pc=1/pc_ctrl=10/offset_addr=0x40, next imem_addr=0x0040.
- No ack for 15 cycles in REQ -> fetch_fault=1 on the 15th edge, imem_req=0; later flush ignored; rst low clears fault and returns to IDLE.
- fetch_en dropped during REQ with ack after 3 cycles -> instruction captured, handed to decode, stage parks in IDLE with imem_req=0.
- rst asserted mid-REQ between clock edges -> imem_req, ir_valid, fetch_fault go 0 immediately without waiting for clk.
